// File: rtl/cpu_pkg.sv
// Shared CPU definitions: flag operation and branch condition encodings,
// processor status bit positions and the status value loaded at reset.
package cpu_pkg;

    typedef enum logic [2:0] {
        FOP_NOP = 3'd0,
        FOP_SEC = 3'd1,
        FOP_CLC = 3'd2,
        FOP_SEI = 3'd3,
        FOP_CLI = 3'd4,
        FOP_SED = 3'd5,
        FOP_CLD = 3'd6,
        FOP_CLV = 3'd7
    } flag_op_t;

    typedef enum logic [2:0] {
        BR_BPL = 3'd0,
        BR_BMI = 3'd1,
        BR_BVC = 3'd2,
        BR_BVS = 3'd3,
        BR_BCC = 3'd4,
        BR_BCS = 3'd5,
        BR_BNE = 3'd6,
        BR_BEQ = 3'd7
    } branch_cond_t;

    // Bit positions inside the packed status byte {N,V,1,B,D,I,Z,C}
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_I = 2;
    localparam int FLAG_D = 3;
    localparam int FLAG_B = 4;
    localparam int FLAG_U = 5;
    localparam int FLAG_V = 6;
    localparam int FLAG_N = 7;

    // Bit positions inside the ALU update mask / ALU flag vector
    localparam int ALU_C = 0;
    localparam int ALU_Z = 1;
    localparam int ALU_N = 2;
    localparam int ALU_V = 3;

    localparam logic [7:0] STATUS_RESET = 8'h34;

    function automatic logic [7:0] pack_status(
        input logic n,
        input logic v,
        input logic b,
        input logic d,
        input logic i,
        input logic z,
        input logic c
    );
        return {n, v, 1'b1, b, d, i, z, c};
    endfunction

endpackage

// File: rtl/status_branch_eval.sv
// Combinational branch condition evaluator: selects one flag test from the
// current N/V/C/Z state according to the branch condition code.
module status_branch_eval
    import cpu_pkg::*;
(
    input  logic       flag_n,
    input  logic       flag_v,
    input  logic       flag_c,
    input  logic       flag_z,
    input  logic [2:0] branch_cond,
    output logic       branch_taken
);

    branch_cond_t cond;
    assign cond = branch_cond_t'(branch_cond);

    always_comb begin
        branch_taken = 1'b0;
        case (cond)
            BR_BPL:  branch_taken = ~flag_n;
            BR_BMI:  branch_taken = flag_n;
            BR_BVC:  branch_taken = ~flag_v;
            BR_BVS:  branch_taken = flag_v;
            BR_BCC:  branch_taken = ~flag_c;
            BR_BCS:  branch_taken = flag_c;
            BR_BNE:  branch_taken = ~flag_z;
            BR_BEQ:  branch_taken = flag_z;
            default: branch_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/status_register.sv
// Processor status register (C,Z,I,D,V,N) with delayed interrupt mask.
// Define STATUS_DECIMAL_EN to store the D flag; otherwise D reads 0.
module status_register
    import cpu_pkg::*;
#(
    parameter logic [7:0] RESET_VALUE = STATUS_RESET
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alu_flag_carry,
    input  logic       alu_flag_zero,
    input  logic       alu_flag_neg,
    input  logic       alu_flag_overflow,
    input  logic [3:0] alu_update_mask,
    input  logic [2:0] flag_op,
    input  logic       load_p,
    input  logic [7:0] data_in,
    input  logic       push_brk,
    input  logic [2:0] branch_cond,
    output logic [7:0] status_out,
    output logic [7:0] push_byte,
    output logic       carry_out,
    output logic       branch_taken,
    output logic       irq_mask
);

    flag_op_t op;
    assign op = flag_op_t'(flag_op);

    logic c_reg, z_reg, i_reg, v_reg, n_reg;
    logic c_next, z_next, i_next, v_next, n_next;
    logic irq_mask_reg;
    logic d_flag;

    logic [3:0] alu_flags;
    logic [3:0] alu_current;
    logic [3:0] alu_merged;

    assign alu_flags   = {alu_flag_overflow, alu_flag_neg, alu_flag_zero, alu_flag_carry};
    assign alu_current = {v_reg, n_reg, z_reg, c_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_alu_merge
            assign alu_merged[gi] = alu_update_mask[gi] ? alu_flags[gi] : alu_current[gi];
        end
    endgenerate

    // Stack load takes the whole byte; otherwise flag_op overrides the ALU write.
    always_comb begin
        c_next = alu_merged[ALU_C];
        z_next = alu_merged[ALU_Z];
        n_next = alu_merged[ALU_N];
        v_next = alu_merged[ALU_V];
        i_next = i_reg;
        if (load_p) begin
            c_next = data_in[FLAG_C];
            z_next = data_in[FLAG_Z];
            i_next = data_in[FLAG_I];
            v_next = data_in[FLAG_V];
            n_next = data_in[FLAG_N];
        end else begin
            case (op)
                FOP_SEC: c_next = 1'b1;
                FOP_CLC: c_next = 1'b0;
                FOP_SEI: i_next = 1'b1;
                FOP_CLI: i_next = 1'b0;
                FOP_CLV: v_next = 1'b0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_reg        <= RESET_VALUE[FLAG_C];
            z_reg        <= RESET_VALUE[FLAG_Z];
            i_reg        <= RESET_VALUE[FLAG_I];
            v_reg        <= RESET_VALUE[FLAG_V];
            n_reg        <= RESET_VALUE[FLAG_N];
            irq_mask_reg <= 1'b1;
        end else begin
            c_reg        <= c_next;
            z_reg        <= z_next;
            i_reg        <= i_next;
            v_reg        <= v_next;
            n_reg        <= n_next;
            irq_mask_reg <= i_reg;
        end
    end

`ifdef STATUS_DECIMAL_EN
    logic d_reg, d_next;

    always_comb begin
        d_next = d_reg;
        if (load_p) begin
            d_next = data_in[FLAG_D];
        end else if (op == FOP_SED) begin
            d_next = 1'b1;
        end else if (op == FOP_CLD) begin
            d_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            d_reg <= RESET_VALUE[FLAG_D];
        end else begin
            d_reg <= d_next;
        end
    end

    assign d_flag = d_reg;

    logic unused_bits;
    assign unused_bits = ^data_in[FLAG_U:FLAG_B];
`else
    assign d_flag = 1'b0;

    // B/U positions are never stored, and D is not stored in this build.
    logic unused_bits;
    assign unused_bits = ^data_in[FLAG_U:FLAG_D];
`endif

    assign status_out = pack_status(n_reg, v_reg, 1'b1, d_flag, i_reg, z_reg, c_reg);
    assign push_byte  = pack_status(n_reg, v_reg, push_brk, d_flag, i_reg, z_reg, c_reg);
    assign carry_out  = c_reg;
    assign irq_mask   = irq_mask_reg;

    status_branch_eval u_branch_eval (
        .flag_n       (n_reg),
        .flag_v       (v_reg),
        .flag_c       (c_reg),
        .flag_z       (z_reg),
        .branch_cond  (branch_cond),
        .branch_taken (branch_taken)
    );

endmodule

// File: tb/tb_status_register.sv
// Self-checking bench for status_register: directed scenarios plus a
// model-driven random run, all results routed through a scoreboard queue.
module tb_status_register;

`ifdef STATUS_DECIMAL_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       alu_flag_carry, alu_flag_zero, alu_flag_neg, alu_flag_overflow;
    logic [3:0] alu_update_mask;
    logic [2:0] flag_op;
    logic       load_p;
    logic [7:0] data_in;
    logic       push_brk;
    logic [2:0] branch_cond;
    logic [7:0] status_out;
    logic [7:0] push_byte;
    logic       carry_out;
    logic       branch_taken;
    logic       irq_mask;

    always #5 clk = ~clk;

    status_register dut (
        .clk               (clk),
        .reset             (reset),
        .alu_flag_carry    (alu_flag_carry),
        .alu_flag_zero     (alu_flag_zero),
        .alu_flag_neg      (alu_flag_neg),
        .alu_flag_overflow (alu_flag_overflow),
        .alu_update_mask   (alu_update_mask),
        .flag_op           (flag_op),
        .load_p            (load_p),
        .data_in           (data_in),
        .push_brk          (push_brk),
        .branch_cond       (branch_cond),
        .status_out        (status_out),
        .push_byte         (push_byte),
        .carry_out         (carry_out),
        .branch_taken      (branch_taken),
        .irq_mask          (irq_mask)
    );

    typedef struct packed {
        logic       rst;
        logic       load;
        logic [7:0] data;
        logic [2:0] op;
        logic [3:0] mask;
        logic [3:0] alu;   // {V,N,Z,C}
        logic       brk;
        logic [2:0] br;
    } stim_t;

    typedef struct packed {
        logic [7:0] status;
        logic       irq;
        logic [7:0] push;
        logic       carry;
        logic       taken;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    function automatic stim_t S(input logic rst, input logic load, input logic [7:0] data,
                                input logic [2:0] op, input logic [3:0] mask, input logic [3:0] alu,
                                input logic brk, input logic [2:0] br);
        return '{rst: rst, load: load, data: data, op: op, mask: mask, alu: alu, brk: brk, br: br};
    endfunction

    function automatic exp_t E(input logic [7:0] status, input logic irq, input logic [7:0] push,
                               input logic carry, input logic taken);
        return '{status: status, irq: irq, push: push, carry: carry, taken: taken};
    endfunction

    function automatic exp_t observe();
        return '{status: status_out, irq: irq_mask, push: push_byte, carry: carry_out, taken: branch_taken};
    endfunction

    task automatic apply(input stim_t s);
        reset             = s.rst;
        load_p            = s.load;
        data_in           = s.data;
        flag_op           = s.op;
        alu_update_mask   = s.mask;
        alu_flag_carry    = s.alu[0];
        alu_flag_zero     = s.alu[1];
        alu_flag_neg      = s.alu[2];
        alu_flag_overflow = s.alu[3];
        push_brk          = s.brk;
        branch_cond       = s.br;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(1, 1, 8'hFF, 3'd1, 4'hF, 4'hF, 1, 3'd0)); ex.push_back(E(8'h34, 1, 8'h34, 0, 1));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 1, 3'd0)); ex.push_back(E(8'h34, 1, 8'h34, 0, 1));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 1, 3'd4)); ex.push_back(E(8'h34, 1, 8'h34, 0, 1));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL reset_state step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_alu_update();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'b0011, 4'hF, 1, 3'd5)); ex.push_back(E(8'h37, 1, 8'h37, 1, 1));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'b0000, 4'h0, 1, 3'd7)); ex.push_back(E(8'h37, 1, 8'h37, 1, 1));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'b0000, 4'h0, 1, 3'd1)); ex.push_back(E(8'h37, 1, 8'h37, 1, 0));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'b0000, 4'h0, 1, 3'd6)); ex.push_back(E(8'h37, 1, 8'h37, 1, 0));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL alu_update step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_flag_op_priority();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        // CLV beats the ALU writing V=1
        st.push_back(S(0, 0, 8'h00, 3'd7, 4'b1000, 4'hF, 1, 3'd2)); ex.push_back(E(8'h37, 1, 8'h37, 1, 1));
        // SEC beats the ALU writing C=0
        st.push_back(S(0, 0, 8'h00, 3'd1, 4'b0001, 4'h0, 1, 3'd5)); ex.push_back(E(8'h37, 1, 8'h37, 1, 1));
        // CLC beats the ALU writing C=1
        st.push_back(S(0, 0, 8'h00, 3'd2, 4'b0001, 4'hF, 1, 3'd4)); ex.push_back(E(8'h36, 1, 8'h36, 0, 1));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL flag_op_priority step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_load_p();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        logic [7:0] s_fb, p_eb;
        s_fb = DEC ? 8'hFB : 8'hF3;
        p_eb = DEC ? 8'hEB : 8'hE3;
        st.push_back(S(0, 1, 8'hCB, 3'd1, 4'hF, 4'h0, 0, 3'd3)); ex.push_back(E(s_fb, 1, p_eb, 1, 1));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 0, 3'd6)); ex.push_back(E(s_fb, 0, p_eb, 1, 0));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL load_p step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_irq_delay();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        logic [7:0] s_i1, s_i0, p_i1, p_i0;
        s_i1 = DEC ? 8'hFF : 8'hF7;
        s_i0 = DEC ? 8'hFB : 8'hF3;
        p_i1 = DEC ? 8'hEF : 8'hE7;
        p_i0 = DEC ? 8'hEB : 8'hE3;
        st.push_back(S(0, 0, 8'h00, 3'd3, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(s_i1, 0, p_i1, 1, 0));
        st.push_back(S(0, 0, 8'h00, 3'd4, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(s_i0, 1, p_i0, 1, 0));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(s_i0, 0, p_i0, 1, 0));
        st.push_back(S(0, 0, 8'h00, 3'd3, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(s_i1, 0, p_i1, 1, 0));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(s_i1, 1, p_i1, 1, 0));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL irq_delay step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_decimal();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 8'h00, 3'd5, 4'h0, 4'h0, 0, 3'd5));
        ex.push_back(E(DEC ? 8'hFF : 8'hF7, 1, DEC ? 8'hEF : 8'hE7, 1, 1));
        st.push_back(S(0, 0, 8'h00, 3'd6, 4'h0, 4'h0, 0, 3'd5));
        ex.push_back(E(8'hF7, 1, 8'hE7, 1, 1));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL decimal step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_sei_vs_load();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 1, 8'h00, 3'd3, 4'hF, 4'hF, 0, 3'd0)); ex.push_back(E(8'h30, 1, 8'h20, 0, 1));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(8'h30, 0, 8'h20, 0, 1));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL sei_vs_load step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_reset_override();
        stim_t st[$];
        exp_t  ex[$];
        exp_t  got, e;
        st.push_back(S(0, 0, 8'h00, 3'd3, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(8'h34, 0, 8'h24, 0, 1));
        st.push_back(S(0, 0, 8'h00, 3'd4, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(8'h30, 1, 8'h20, 0, 1));
        // irq_mask would fall next cycle; reset must drop that pending change
        st.push_back(S(1, 1, 8'h00, 3'd4, 4'hF, 4'hF, 0, 3'd0)); ex.push_back(E(8'h34, 1, 8'h24, 0, 1));
        st.push_back(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 0, 3'd0)); ex.push_back(E(8'h34, 1, 8'h24, 0, 1));
        foreach (st[k]) begin
            apply(st[k]);
            sb.push_back(ex[k]);
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL reset_override step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    task automatic test_back_to_back_random();
        logic mc, mz, mi, md, mv, mn, mirq, old_i, tk;
        stim_t s;
        exp_t  got, e;
        mc = 0; mz = 0; mi = 1; md = 0; mv = 0; mn = 0; mirq = 1;
        for (int k = 0; k < 60; k++) begin
            s = S((k == 0) || ($urandom_range(0, 15) == 0), ($urandom_range(0, 5) == 0),
                  8'($urandom), 3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 3'($urandom));
            if (s.rst) begin
                mc = 0; mz = 0; mi = 1; md = 0; mv = 0; mn = 0; mirq = 1;
            end else begin
                old_i = mi;
                if (s.load) begin
                    {mn, mv} = s.data[7:6];
                    md = DEC & s.data[3];
                    {mi, mz, mc} = s.data[2:0];
                end else begin
                    if (s.mask[0]) mc = s.alu[0];
                    if (s.mask[1]) mz = s.alu[1];
                    if (s.mask[2]) mn = s.alu[2];
                    if (s.mask[3]) mv = s.alu[3];
                    case (s.op)
                        3'd1: mc = 1'b1;
                        3'd2: mc = 1'b0;
                        3'd3: mi = 1'b1;
                        3'd4: mi = 1'b0;
                        3'd5: md = DEC;
                        3'd6: md = 1'b0;
                        3'd7: mv = 1'b0;
                        default: ;
                    endcase
                end
                mirq = old_i;
            end
            case (s.br)
                3'd0: tk = !mn;
                3'd1: tk = mn;
                3'd2: tk = !mv;
                3'd3: tk = mv;
                3'd4: tk = !mc;
                3'd5: tk = mc;
                3'd6: tk = !mz;
                default: tk = mz;
            endcase
            apply(s);
            sb.push_back(E({mn, mv, 2'b11, md, mi, mz, mc}, mirq,
                           {mn, mv, 1'b1, s.brk, md, mi, mz, mc}, mc, tk));
            tick();
            got = observe();
            e = sb.pop_front();
            checks++;
            if (got !== e) $display("FAIL random step %0d got=%h exp=%h", k, got, e);
            else passed++;
        end
    endtask

    initial begin
        apply(S(0, 0, 8'h00, 3'd0, 4'h0, 4'h0, 1, 3'd0));
        test_reset();
        test_alu_update();
        test_flag_op_priority();
        test_load_p();
        test_irq_delay();
        test_decimal();
        test_sei_vs_load();
        test_reset_override();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
